// File: rtl/dm_byte_ctrl_pkg.sv
// rtl/dm_byte_ctrl_pkg.sv - shared constants, state and op encodings for dm_byte_ctrl
//
// Contents:
//   DEPTH / AW / DW  : memory geometry (256 x 32-bit words, 10-bit byte address)
//   state_t          : controller FSM states
//   op_t             : latched operation kind
//   decode_op()      : maps the we/sb request qualifiers onto op_t

package dm_byte_ctrl_pkg;

    localparam int DEPTH = 256;
    localparam int AW    = 10;
    localparam int DW    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_MG   = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_LW = 2'd0,
        OP_SW = 2'd1,
        OP_SB = 2'd2
    } op_t;

    // sb only qualifies a store; a load with sb set is still a plain word load.
    function automatic op_t decode_op(input logic we, input logic sb);
        op_t op;
        if (!we) begin
            op = OP_LW;
        end else if (sb) begin
            op = OP_SB;
        end else begin
            op = OP_SW;
        end
        return op;
    endfunction

endpackage

// File: rtl/dm_byte_ctrl_byte_merge.sv
// rtl/dm_byte_ctrl_byte_merge.sv - replaces one byte lane of a 32-bit word
//
// Ports:
//   word_i [31:0] : original word
//   byte_i [7:0]  : replacement byte
//   lane_i [1:0]  : lane to replace (0 = bits 7:0 ... 3 = bits 31:24)
//   word_o [31:0] : merged word; the other three bytes pass through unchanged

module byte_merge (
    input  logic [31:0] word_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = word_i;
        case (lane_i)
            2'd0: word_o[7:0]   = byte_i;
            2'd1: word_o[15:8]  = byte_i;
            2'd2: word_o[23:16] = byte_i;
            2'd3: word_o[31:24] = byte_i;
            default: word_o = word_i;
        endcase
    end

endmodule

// File: rtl/dm_byte_ctrl.sv
// rtl/dm_byte_ctrl.sv - data-memory controller: word load, word store, byte store via read-modify-write
//
// Ports:
//   clk_i         : rising-edge clock
//   rst_i         : asynchronous active-high reset (also clears the whole RAM)
//   req_i         : request strobe, sampled only while idle
//   we_i          : 0 = load, 1 = store
//   sb_i          : with we_i = 1 selects a byte store
//   addr_i [9:0]  : byte address; word index is addr_i[9:2], lane is addr_i[1:0]
//   din_i  [31:0] : store data (only [7:0] used for byte stores)
//   dout_o [31:0] : word returned by the last completed load
//   busy_o        : high whenever an operation is in flight
//   done_o        : one-cycle completion pulse, in the first idle cycle after completion

module dm_byte_ctrl
    import dm_byte_ctrl_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic          sb_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          busy_o,
    output logic          done_o
);

    state_t        state_q, state_d;
    op_t           op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] dout_q, dout_d;
    logic          done_q, done_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic          accept;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] merged;
    logic [7:0]    word_idx;
    logic [DW-1:0] rd_word;

    assign word_idx = addr_q[AW-1:2];
    assign rd_word  = mem_q[word_idx];
    assign accept   = (state_q == ST_IDLE) && req_i;

    // The merge works on the word captured in RD, not a fresh RAM read, so
    // the write in MG is a pure register-to-RAM transfer.
    byte_merge u_byte_merge (
        .word_i (rdata_q),
        .byte_i (din_q[7:0]),
        .lane_i (addr_q[1:0]),
        .word_o (merged)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = (decode_op(we_i, sb_i) == OP_SW) ? ST_WR : ST_RD;
                end
            end
            ST_RD:   state_d = (op_q == OP_SB) ? ST_MG : ST_IDLE;
            ST_MG:   state_d = ST_IDLE;
            ST_WR:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        busy_o    = (state_q != ST_IDLE);
        mem_we    = 1'b0;
        mem_wdata = din_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        case (state_q)
            ST_RD: begin
                if (op_q == OP_LW) begin
                    dout_d = rd_word;
                    done_d = 1'b1;
                end
            end
            ST_MG: begin
                mem_we    = 1'b1;
                mem_wdata = merged;
                done_d    = 1'b1;
            end
            ST_WR: begin
                mem_we = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Request capture and result registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q    <= OP_LW;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= decode_op(we_i, sb_i);
                addr_q <= addr_i;
                din_q  <= din_i;
            end
            if (state_q == ST_RD) begin
                rdata_q <= rd_word;
            end
            dout_q <= dout_d;
            done_q <= done_d;
        end
    end

    // RAM; reset wipes every word so an aborted byte store leaves nothing behind.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[word_idx] <= mem_wdata;
        end
    end

    assign dout_o = dout_q;
    assign done_o = done_q;

endmodule

// File: doc/dm_byte_ctrl.md
# dm_byte_ctrl

Data-memory controller sitting directly upstream of the load-byte extractor: owns the 256-word data RAM, services word loads, word stores and byte stores (`sb`), and presents the full 32-bit word on `dout` for downstream byte selection. Byte stores run as a two-step read-modify-write under a small FSM, with `busy`/`done` handshaking to the multicycle control unit.

## Interface
- `DEPTH`, 256, number of 32-bit words; word index is `addr[9:2]`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `we`  in  1  0 = load, 1 = store.
- `sb`  in  1  with `we`=1 selects byte store; ignored when `we`=0.
- `addr`  in  10  byte address; `addr[1:0]` is the byte lane for `sb`, ignored for word ops.
- `din`  in  32  store data; only `din[7:0]` is used for `sb`.
- `dout`  out  32  registered word from the last completed load, raw and not sign-extended.
- `busy`  out  1  combinational, high whenever the state is not IDLE.
- `done`  out  1  registered one-cycle pulse when an operation completes.

## Operation
- States: IDLE, RD, MG, WR.
- At an IDLE edge with `req`=1, latch `addr_q`, `din_q` and op (LW / SW / SB).
  - LW → RD; SB → RD; SW → WR.
- RD edge: `rdata_q <= mem[addr_q[9:2]]`.
  - LW: `dout <= mem[...]`, `done <= 1`, → IDLE.
  - SB: → MG; `dout` is unchanged.
- MG edge: `mem[word] <= rdata_q` with lane `addr_q[1:0]` replaced by `din_q[7:0]`.
  - Lane 0 = bits 7:0, lane 1 = bits 15:8, lane 2 = bits 23:16, lane 3 = bits 31:24.
  - Other three bytes are preserved bit-exactly; `done <= 1`; → IDLE.
- WR edge: `mem[word] <= din_q`, `done <= 1`, → IDLE.
- `req` while `busy` is ignored; there is no queueing.
- `din` and `addr` changes after acceptance have no effect.
- `done` is high for exactly one cycle, the first IDLE cycle after completion. A new `req` is accepted in that same cycle.
- Stores never modify `dout`. `rdata_q` is internal only.

## Timing
- Reset (async, mid-operation included):
  - state returns to IDLE; `done`=0, `dout`=0, `rdata_q`=0;
  - all memory words are cleared to 0;
  - an in-flight SB aborts with no partial write.
- Latency, from the accepting edge E0:
  - LW: `dout` valid and `done`=1 after E1.
  - SW: memory written at E1; `done`=1 after E1.
  - SB: read at E1, write at E2; `done`=1 after E2.
- `busy` = 1 from after E0 until the completing edge. Throughput is one op per 2 cycles (LW/SW) or 3 cycles (SB).
- Back-to-back ops: a load issued in the `done` cycle of a store to the same word returns the updated data.
- Address wrap: `addr[9:2]` = 255 is the last word; there is no out-of-range behaviour.

## Structure
- Shared package holds:
  - state encodings: IDLE=2'd0, RD=2'd1, MG=2'd2, WR=2'd3;
  - op encodings: LW, SW, SB;
  - the `DEPTH` constant.
- One natural sub-module, `byte_merge` (combinational). Inputs: 32-bit word, 8-bit byte, 2-bit lane. Output: 32-bit merged word. It is instantiated once on the MG write path.

## Test plan
- Reset then LW at 0x000 → `dout`=0x00000000, `done` pulses exactly once, 2 cycles after `req`.
- SW 0x12345678 to 0x010, then LW 0x013 → `dout`=0x12345678 (low address bits ignored); `busy` is high for 1 cycle per op.
- After the SW above, SB `din`=0xFFFFFFAB at 0x012, then LW 0x010:
  - `dout`=0x12AB5678;
  - SB `done` arrives 3 cycles after `req`;
  - `dout` is unchanged during the SB.
- SB to all four lanes of 0x020 with bytes 0x11, 0x22, 0x33, 0x44 (lanes 0 through 3) → LW gives 0x44332211.
- `req` pulsed during SB's RD and MG cycles → ignored; only the SB completes and the memory matches a single op.
- Async `rst` asserted in MG of an SB to 0x030 (word preloaded 0xAAAAAAAA) → state IDLE, `busy`=0 and `dout`=0 immediately; LW 0x030 after release returns 0.
